// File: rtl/bist_response_checker_if.sv
// Port bundle between the BIST controller and the response checker:
// read-check stream and test control in, status and signature out.
interface bist_response_checker_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     start;
    logic                     end_of_test;
    logic                     rd_valid;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [DATA_WIDTH-1:0]    exp_data;

    logic                     busy;
    logic                     done;
    logic                     pass;
    logic                     fail_seen;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [ADDR_WIDTH-1:0]    first_fail_addr;
    logic [DATA_WIDTH-1:0]    first_fail_syn;
    logic [DATA_WIDTH-1:0]    misr_sig;

    modport master (
        output start, end_of_test, rd_valid, rd_addr, rd_data, exp_data,
        input  busy, done, pass, fail_seen, err_count,
               first_fail_addr, first_fail_syn, misr_sig
    );

    modport slave (
        input  start, end_of_test, rd_valid, rd_addr, rd_data, exp_data,
        output busy, done, pass, fail_seen, err_count,
               first_fail_addr, first_fail_syn, misr_sig
    );
endinterface

// File: rtl/bist_response_checker.sv
// BIST response checker: 2-stage compare pipeline, saturating miscompare
// count, first-fail capture and MISR compaction of all read-back data.
module bist_response_checker #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 10,
    parameter int                    ERR_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] MISR_SEED     = 32'hFFFF_FFFF
) (
    input logic                    clk,
    input logic                    rst,
    bist_response_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] exp;
    } s1_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] syn;
    } s2_t;

    state_e                   state_q, state_d;
    logic                     drain_cnt_q, drain_cnt_d;
    logic [1:0]               vld_pipe_q, vld_pipe_d;
    s1_t                      s1_q, s1_d;
    s2_t                      s2_q, s2_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                     fail_seen_q, fail_seen_d;
    logic [ADDR_WIDTH-1:0]    ff_addr_q, ff_addr_d;
    logic [DATA_WIDTH-1:0]    ff_syn_q, ff_syn_d;
    logic [DATA_WIDTH-1:0]    misr_q, misr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;

    logic                     miscmp;
    logic                     misr_fb;

    assign miscmp  = vld_pipe_q[1] && (s2_q.syn != '0);
    // x^32 + x^22 + x^2 + x + 1
    assign misr_fb = misr_q[DATA_WIDTH-1] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0];

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        err_count_d = err_count_q;
        fail_seen_d = fail_seen_q;
        ff_addr_d   = ff_addr_q;
        ff_syn_d    = ff_syn_q;
        misr_d      = misr_q;

        s1_d.addr     = bus.rd_addr;
        s1_d.data     = bus.rd_data;
        s1_d.exp      = bus.exp_data;
        vld_pipe_d[0] = bus.rd_valid && (state_q == RUN);

        s2_d.addr     = s1_q.addr;
        s2_d.data     = s1_q.data;
        s2_d.syn      = s1_q.data ^ s1_q.exp;
        vld_pipe_d[1] = vld_pipe_q[0];

        if (vld_pipe_q[1]) begin
            misr_d = {misr_q[DATA_WIDTH-2:0], misr_fb} ^ s2_q.data;
        end

        if (miscmp) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            fail_seen_d = 1'b1;
            if (!fail_seen_q) begin
                ff_addr_d = s2_q.addr;
                ff_syn_d  = s2_q.syn;
            end
        end

        case (state_q)
            RUN: begin
                if (bus.end_of_test) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            // The read sampled with end_of_test reaches the result stage on
            // the second DRAIN edge, so leaving then still applies it.
            DRAIN: begin
                if (drain_cnt_q && !vld_pipe_q[0]) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (bus.start) begin
            state_d     = RUN;
            drain_cnt_d = 1'b0;
            vld_pipe_d  = '0;
            err_count_d = '0;
            fail_seen_d = 1'b0;
            ff_addr_d   = '0;
            ff_syn_d    = '0;
            misr_d      = MISR_SEED;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
            vld_pipe_q  <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            err_count_q <= '0;
            fail_seen_q <= 1'b0;
            ff_addr_q   <= '0;
            ff_syn_q    <= '0;
            misr_q      <= MISR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            err_count_q <= err_count_d;
            fail_seen_q <= fail_seen_d;
            ff_addr_q   <= ff_addr_d;
            ff_syn_q    <= ff_syn_d;
            misr_q      <= misr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.fail_seen       = fail_seen_q;
    assign bus.err_count       = err_count_q;
    assign bus.first_fail_addr = ff_addr_q;
    assign bus.first_fail_syn  = ff_syn_q;
    assign bus.misr_sig        = misr_q;

endmodule
